// File: rtl/array_seq_pkg.sv
// Shared types and helpers for the systolic array tile sequencer.
// Holds the FSM state enum, mode encodings and the drain latency helper.
package array_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        OUT,
        NEXT,
        DONE
    } state_t;

    localparam logic MODE_PER_TILE = 1'b0;
    localparam logic MODE_ACCUM    = 1'b1;

    // Cycles from the last operand pop until the final psum is capturable.
    function automatic int drain_lat(
        input int rows,
        input int cols,
        input int pipe_extra
    );
        return rows + cols - 1 + pipe_extra;
    endfunction

endpackage

// File: rtl/array_sequencer_counter.sv
// seq_counter: loadable up-counter with clear, enable and terminal flag.
// Ports: i_clk, i_nrst, clr (sync, top priority), load/load_val,
// en (increment), term (terminal value), count, tc (count == term).
module seq_counter
    import array_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/array_sequencer.sv
// array_sequencer: multi-tile sequencer between the CSR block and the
// IR/WR/OR routers. Arms routers, issues pop strobes, waits the array
// drain latency per tile, then drives psum readout and the output router.
// Ports: i_clk/i_nrst, i_reg_clear, i_start, i_num_tiles, i_mode,
// router enables/readies/dones, pop/tile_next/psum pulses, o_tile_idx,
// o_busy, o_done (sticky).
module array_sequencer
    import array_seq_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int PIPE_EXTRA = 0,
    parameter int TILE_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [TILE_WIDTH-1:0] i_num_tiles,
    input  logic                  i_mode,
    output logic                  o_ir_en,
    output logic                  o_wr_en,
    input  logic                  i_ir_ready,
    input  logic                  i_wr_ready,
    output logic                  o_pop_en,
    input  logic                  i_ir_done,
    input  logic                  i_wr_done,
    output logic                  o_tile_next,
    output logic                  o_psum_clear,
    output logic                  o_psum_out_en,
    output logic                  o_or_en,
    input  logic                  i_or_done,
    output logic [TILE_WIDTH-1:0] o_tile_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int DLAT = drain_lat(ROWS, COLS, PIPE_EXTRA);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DLAT - 1);

    state_t                  state;
    logic [TILE_WIDTH-1:0]   n_q;
    logic                    mode_q;
    logic [CNT_WIDTH-1:0]    drain_cnt_unused;
    logic                    drain_tc;
    logic                    last_tile;
    logic                    accept;

    assign accept = (state == IDLE) && i_start;

    // Free-runs only inside DRAIN; held at zero elsewhere so each
    // DRAIN visit starts counting from 0.
    seq_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_drain_cnt (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .clr      (i_reg_clear || (state != DRAIN)),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == DRAIN),
        .term     (DRAIN_LAST),
        .count    (drain_cnt_unused),
        .tc       (drain_tc)
    );

    // Tile index saturates at N-1 so it can never wrap.
    seq_counter #(
        .WIDTH (TILE_WIDTH)
    ) u_tile_cnt (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .clr      (i_reg_clear),
        .load     (accept),
        .load_val ('0),
        .en       ((state == NEXT) && !last_tile),
        .term     (n_q - TILE_WIDTH'(1)),
        .count    (o_tile_idx),
        .tc       (last_tile)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state         <= IDLE;
            n_q           <= '0;
            mode_q        <= MODE_PER_TILE;
            o_ir_en       <= 1'b0;
            o_wr_en       <= 1'b0;
            o_pop_en      <= 1'b0;
            o_tile_next   <= 1'b0;
            o_psum_clear  <= 1'b0;
            o_psum_out_en <= 1'b0;
            o_or_en       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else if (i_reg_clear) begin
            state         <= IDLE;
            n_q           <= '0;
            mode_q        <= MODE_PER_TILE;
            o_ir_en       <= 1'b0;
            o_wr_en       <= 1'b0;
            o_pop_en      <= 1'b0;
            o_tile_next   <= 1'b0;
            o_psum_clear  <= 1'b0;
            o_psum_out_en <= 1'b0;
            o_or_en       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_tile_next   <= 1'b0;
            o_psum_clear  <= 1'b0;
            o_psum_out_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        n_q          <= (i_num_tiles == '0) ?
                                        TILE_WIDTH'(1) : i_num_tiles;
                        mode_q       <= i_mode;
                        o_ir_en      <= 1'b1;
                        o_wr_en      <= 1'b1;
                        o_psum_clear <= 1'b1;
                        o_done       <= 1'b0;
                        o_busy       <= 1'b1;
                        state        <= FEED;
                    end
                end
                FEED: begin
                    if (i_ir_done && i_wr_done) begin
                        o_pop_en <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        o_pop_en <= i_ir_ready && i_wr_ready;
                    end
                end
                DRAIN: begin
                    if (drain_tc) begin
                        if (mode_q == MODE_PER_TILE || last_tile) begin
                            o_psum_out_en <= 1'b1;
                            state         <= OUT;
                        end else begin
                            o_tile_next <= 1'b1;
                            state       <= NEXT;
                        end
                    end
                end
                OUT: begin
                    // or_en rises one cycle after OUT entry, so a done
                    // already high on entry means it never asserts.
                    if (i_or_done) begin
                        o_or_en <= 1'b0;
                        if (last_tile) begin
                            state <= DONE;
                        end else begin
                            o_tile_next  <= 1'b1;
                            o_psum_clear <= (mode_q == MODE_PER_TILE);
                            state        <= NEXT;
                        end
                    end else begin
                        o_or_en <= 1'b1;
                    end
                end
                NEXT: begin
                    state <= FEED;
                end
                DONE: begin
                    o_done  <= 1'b1;
                    o_ir_en <= 1'b0;
                    o_wr_en <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_sequencer.sv
// Testbench for array_sequencer: directed and randomized jobs checked
// against expectations derived from the job parameters.
module tb_array_sequencer;

    localparam int TW   = 8;
    localparam int DLAT = 4 + 4 - 1 + 0;

    logic          i_clk = 1'b0;
    logic          i_nrst;
    logic          i_reg_clear;
    logic          i_start;
    logic [TW-1:0] i_num_tiles;
    logic          i_mode;
    logic          o_ir_en;
    logic          o_wr_en;
    logic          i_ir_ready;
    logic          i_wr_ready;
    logic          o_pop_en;
    logic          i_ir_done;
    logic          i_wr_done;
    logic          o_tile_next;
    logic          o_psum_clear;
    logic          o_psum_out_en;
    logic          o_or_en;
    logic          i_or_done;
    logic [TW-1:0] o_tile_idx;
    logic          o_busy;
    logic          o_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_out, cnt_next, cnt_clr, cnt_pop, exp_pop;

    array_sequencer #(
        .ROWS       (4),
        .COLS       (4),
        .PIPE_EXTRA (0),
        .TILE_WIDTH (TW),
        .CNT_WIDTH  (8)
    ) dut (
        .i_clk         (i_clk),
        .i_nrst        (i_nrst),
        .i_reg_clear   (i_reg_clear),
        .i_start       (i_start),
        .i_num_tiles   (i_num_tiles),
        .i_mode        (i_mode),
        .o_ir_en       (o_ir_en),
        .o_wr_en       (o_wr_en),
        .i_ir_ready    (i_ir_ready),
        .i_wr_ready    (i_wr_ready),
        .o_pop_en      (o_pop_en),
        .i_ir_done     (i_ir_done),
        .i_wr_done     (i_wr_done),
        .o_tile_next   (o_tile_next),
        .o_psum_clear  (o_psum_clear),
        .o_psum_out_en (o_psum_out_en),
        .o_or_en       (o_or_en),
        .i_or_done     (i_or_done),
        .o_tile_idx    (o_tile_idx),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (o_psum_out_en) cnt_out++;
        if (o_tile_next) cnt_next++;
        if (o_psum_clear) cnt_clr++;
        if (o_pop_en) cnt_pop++;
    endtask

    function automatic logic [8:0] outs();
        return {o_ir_en, o_wr_en, o_pop_en, o_tile_next, o_psum_clear,
                o_psum_out_en, o_or_en, o_busy, o_done};
    endfunction

    // rdy_mode: 0 random, 1 both high, 2 ir only. feed_len < 0: random.
    task automatic run_job(input int n_in, input bit md, input int feed_len,
                           input int rdy_mode, input int or_max,
                           input bit start_noise, input int abort_tile);
        int n, len, w;
        bit prev_pop;
        n = (n_in == 0) ? 1 : n_in;
        cnt_out = 0; cnt_next = 0; cnt_clr = 0; cnt_pop = 0; exp_pop = 0;
        i_start = 1'b1;
        i_num_tiles = TW'(n_in);
        i_mode = md;
        tick();
        i_start = 1'b0;
        i_num_tiles = TW'($urandom_range(0, 9));
        i_mode = 1'($urandom);
        check("start_en", {30'd0, o_ir_en, o_wr_en}, 32'h3);
        check("start_clr", o_psum_clear, 1);
        check("start_done", o_done, 0);
        check("start_busy", o_busy, 1);
        for (int t = 0; t < n; t++) begin
            check("feed_idx", o_tile_idx, t);
            check("feed_pop0", o_pop_en, 0);
            check("feed_next0", o_tile_next, 0);
            prev_pop = 1'b0;
            len = (feed_len < 0) ? $urandom_range(0, 6) : feed_len;
            for (int k = 0; k < len; k++) begin
                int r;
                r = $urandom_range(0, 3);
                unique case (rdy_mode)
                    1: begin i_ir_ready = 1'b1; i_wr_ready = 1'b1; end
                    2: begin i_ir_ready = 1'b1; i_wr_ready = 1'b0; end
                    default: begin
                        i_ir_ready = 1'($urandom);
                        i_wr_ready = 1'($urandom);
                    end
                endcase
                i_ir_done = (r == 1);
                i_wr_done = (r == 2);
                i_start = start_noise && (r == 3);
                i_num_tiles = TW'($urandom_range(0, 9));
                prev_pop = i_ir_ready && i_wr_ready;
                if (prev_pop) exp_pop++;
                tick();
                check("pop", o_pop_en, prev_pop);
                check("feed_idx_hold", o_tile_idx, t);
            end
            i_ir_done = 1'b1;
            i_wr_done = 1'b1;
            i_ir_ready = 1'($urandom);
            i_wr_ready = 1'($urandom);
            i_start = start_noise;
            tick();
            i_ir_done = 1'b0;
            i_wr_done = 1'b0;
            i_ir_ready = 1'b0;
            i_wr_ready = 1'b0;
            i_start = 1'b0;
            check("drain_pop", o_pop_en, 0);
            check("drain_idx", o_tile_idx, t);
            for (int j = 0; j < DLAT; j++) begin
                check("drain_out", o_psum_out_en, 0);
                if (t == abort_tile && j == 3) begin
                    i_reg_clear = 1'b1;
                    i_start = 1'b1;
                    tick();
                    i_reg_clear = 1'b0;
                    i_start = 1'b0;
                    check("clr_outs", outs(), 0);
                    check("clr_idx", o_tile_idx, 0);
                    tick();
                    check("clr_idle", outs(), 0);
                    return;
                end
                tick();
            end
            if (md == 1'b0 || t == n - 1) begin
                check("out_pulse", o_psum_out_en, 1);
                check("or_en_first", o_or_en, 0);
                w = $urandom_range(0, or_max);
                i_or_done = (w == 0);
                for (int k = 1; k <= w; k++) begin
                    tick();
                    check("or_en_hold", o_or_en, 1);
                    check("out_once", o_psum_out_en, 0);
                    i_or_done = (k == w);
                end
                tick();
                i_or_done = 1'b0;
                check("or_en_off", o_or_en, 0);
                if (t == n - 1) begin
                    check("done_wait", o_done, 0);
                    check("done_next", o_tile_next, 0);
                    tick();
                    check("done_set", o_done, 1);
                    check("done_idle", {o_ir_en, o_wr_en, o_busy}, 0);
                end else begin
                    check("next_pulse", o_tile_next, 1);
                    check("next_clr", o_psum_clear, 1);
                    tick();
                end
            end else begin
                check("acc_next", o_tile_next, 1);
                check("acc_clr", o_psum_clear, 0);
                check("acc_out", o_psum_out_en, 0);
                tick();
            end
        end
        check("n_out", cnt_out, md ? 1 : n);
        check("n_next", cnt_next, n - 1);
        check("n_clr", cnt_clr, md ? 1 : n);
        check("n_pop", cnt_pop, exp_pop);
        tick();
        tick();
        check("done_sticky", {o_done, o_busy}, 2'b10);
        check("idle_quiet", outs(), 9'b000000001);
    endtask

    initial begin
        i_nrst = 1'b0;
        i_reg_clear = 1'b0;
        i_start = 1'b0;
        i_num_tiles = '0;
        i_mode = 1'b0;
        i_ir_ready = 1'b0;
        i_wr_ready = 1'b0;
        i_ir_done = 1'b0;
        i_wr_done = 1'b0;
        i_or_done = 1'b0;
        tick();
        tick();
        check("rst_outs", outs(), 0);
        check("rst_idx", o_tile_idx, 0);
        i_nrst = 1'b1;
        tick();
        check("post_rst", outs(), 0);

        run_job(1, 1'b0, 5, 1, 3, 1'b0, -1);
        run_job(3, 1'b0, -1, 0, 3, 1'b0, -1);
        run_job(3, 1'b1, -1, 0, 3, 1'b0, -1);
        run_job(0, 1'b0, 4, 0, 2, 1'b1, -1);
        run_job(2, 1'b0, 5, 2, 2, 1'b0, -1);
        run_job(1, 1'b0, 3, 1, 0, 1'b0, -1);
        run_job(3, 1'b0, -1, 0, 2, 1'b0, 1);
        check("clr_done", o_done, 0);
        run_job(3, 1'b0, -1, 0, 2, 1'b0, -1);
        for (int i = 0; i < 10; i++) begin
            run_job($urandom_range(0, 4), 1'($urandom), -1, 0, 3,
                    1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
